// File: rtl/sr_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied when the result is loaded.
module sr_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             abort,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   mcand_reg, hi_reg, lo_reg, result_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Request decode, evaluated on the live inputs in the accepting cycle.
  logic               is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic               div_zero, ovf, special, accept;
  logic [WIDTH-1:0]   a_mag, b_mag, special_val;

  always_comb begin
    is_div   = oper[2];
    a_signed = (oper == 3'b001) || (oper == 3'b010) || (oper == 3'b100) || (oper == 3'b110);
    b_signed = (oper == 3'b001) || (oper == 3'b100) || (oper == 3'b110);
    a_neg    = a_signed & srcA[WIDTH-1];
    b_neg    = b_signed & srcB[WIDTH-1];
    a_mag    = a_neg ? -srcA : srcA;
    b_mag    = b_neg ? -srcB : srcB;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    neg_in   = (is_div && oper[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (srcB == '0);
    ovf      = is_div && !oper[0] && (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (&srcB);
    special  = div_zero || ovf;
    special_val = '0;
    if (div_zero) special_val = oper[1] ? srcA : '1;
    else if (ovf) special_val = oper[1] ? '0 : srcA;
  end

  // One iteration of the shared datapath on the latched operands.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff, hi_step, lo_step, q_fix, r_fix, final_val;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_reg};
    div_diff  = div_shift[WIDTH-1:0] - mcand_reg;
    if (op_reg[2]) begin
      hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
    prod     = {hi_step, lo_step};
    prod_fix = neg_reg ? -prod : prod;
    q_fix    = neg_reg ? -lo_step : lo_step;
    r_fix    = neg_reg ? -hi_step : hi_step;
    case (op_reg)
      3'b000:                 final_val = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_val = q_fix;
      default:                final_val = r_fix;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          accept     = 1'b1;
          state_next = special ? DONE : CALC;
        end
      end
      CALC:    if (cnt_reg == '0) state_next = DONE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a start on the same edge.
    if (abort) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= oper;
        neg_reg   <= neg_in;
        hi_reg    <= '0;
        mcand_reg <= is_div ? b_mag : a_mag;
        lo_reg    <= is_div ? a_mag : b_mag;
        cnt_reg   <= CNT_W'(WIDTH - 1);
        if (special) result_reg <= special_val;
      end else if (state_reg == CALC && !abort) begin
        hi_reg  <= hi_step;
        lo_reg  <= lo_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) result_reg <= final_val;
      end
    end
  end

  assign busy   = (state_reg == CALC);
  assign valid  = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_sr_mdu.sv
// Scoreboard bench for sr_mdu: drivers push expected result and due cycle,
// monitors pop and compare whenever valid is seen.
module tb_sr_mdu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, busy, valid;
  logic [2:0]  oper = '0;
  logic [31:0] src_a = '0, src_b = '0, result;

  logic        start8 = 1'b0, busy8, valid8;
  logic [2:0]  oper8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, result8;

  sr_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(src_a), .srcB(src_b),
    .abort(abort), .busy(busy), .valid(valid), .result(result)
  );

  sr_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(a8), .srcB(b8),
    .abort(1'b0), .busy(busy8), .valid(valid8), .result(result8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0, busy_cnt = 0, txn = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];
  logic [7:0]  exp8_q[$];
  int          due8_q[$];
  logic [31:0] mon_exp;
  int          mon_due;
  logic [7:0]  mon_exp8;
  int          mon_due8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && valid) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_valid_overlap: busy=1 valid=1 at cycle %0d, expected never both", cyc);
    end
    if (valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_valid: valid=1 result=%h at cycle %0d, expected no valid", result, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_due = due_q.pop_front();
        txn++;
        $display("txn %0d: result=%h expected=%h cycle=%0d due=%0d", txn, result, mon_exp, cyc, mon_due);
        check("result", result, mon_exp);
        check("latency", 32'(cyc), 32'(mon_due));
      end
    end
  end

  always @(negedge clk) begin
    if (valid8) begin
      if (exp8_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_valid8: valid=1 result=%h, expected no valid", result8);
      end else begin
        mon_exp8 = exp8_q.pop_front();
        mon_due8 = due8_q.pop_front();
        $display("txn w8: result=%h expected=%h cycle=%0d due=%0d", result8, mon_exp8, cyc, mon_due8);
        check("result_w8", {24'h0, result8}, {24'h0, mon_exp8});
        check("latency_w8", 32'(cyc), 32'(mon_due8));
      end
    end
  end

  // One-cycle start; lat counts from the start cycle to the valid cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit chk);
    @(negedge clk);
    start = 1'b1; oper = op; src_a = a; src_b = b;
    if (chk) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + lat);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(op, a, b, exp, lat, 1'b1);
    drain(60);
  endtask

  localparam int LAT = 33;
  bit got_valid;

  initial begin
    #12;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    busy_cnt = 0;
    run(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    run(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);
    run(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
    run(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
    run(3'b101, 32'd100, 32'd7, 32'd14, LAT);
    run(3'b111, 32'd100, 32'd7, 32'd2, LAT);

    busy_cnt = 0;
    run(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run(3'b111, 32'd5, 32'd0, 32'd5, 1);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    check("special_busy_cycles", 32'(busy_cnt), 32'd0);

    // Start while busy must be ignored.
    issue(3'b000, 32'd6, 32'd7, 32'd42, LAT, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; oper = 3'b101; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (40) @(negedge clk);

    // Back-to-back: new start presented in the DONE cycle.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, 1'b1);
    got_valid = 1'b0;
    for (int i = 0; i < 60 && !got_valid; i++) begin
      @(negedge clk);
      if (valid) got_valid = 1'b1;
    end
    check("b2b_first_valid", {31'h0, got_valid}, 32'h1);
    start = 1'b1; oper = 3'b101; src_a = 32'd100; src_b = 32'd7;
    exp_q.push_back(32'd14);
    due_q.push_back(cyc + LAT);
    @(negedge clk);
    start = 1'b0;
    drain(60);

    // Abort in CALC cycle 10.
    issue(3'b000, 32'd9, 32'd9, 32'd0, LAT, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_valid", {31'h0, valid}, 32'h0);
    repeat (40) @(negedge clk);
    check("abort_result_held", result, 32'd14);

    // Asynchronous reset mid-CALC.
    issue(3'b000, 32'd9, 32'd9, 32'd0, LAT, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_valid", {31'h0, valid}, 32'h0);
    check("midreset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'b000, 32'd3, 32'd5, 32'd15, LAT);

    // Narrow instance: MULHU 0xFF x 0xFF.
    @(negedge clk);
    start8 = 1'b1; oper8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF;
    exp8_q.push_back(8'hFE);
    due8_q.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 30 && exp8_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp8_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_w8: %0d results pending, expected 0", exp8_q.size());
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
